// File: rtl/mux_arb_n_if.sv
// mux_arb_n_if: input-channel and output handshake bundle for mux_arb_n
interface mux_arb_n_if #(
    parameter int WIDTH = 4,
    parameter int NCH   = 3,
    parameter int SELW  = 2
);
    logic [NCH*WIDTH-1:0] in_data;
    logic [NCH-1:0]       in_valid;
    logic [NCH-1:0]       in_ready;
    logic                 mode;
    logic [SELW-1:0]      sel;
    logic [WIDTH-1:0]     out_data;
    logic                 out_valid;
    logic                 out_ready;
    logic [SELW-1:0]      out_ch;
    logic                 err;
    modport master (
        output in_data, in_valid, mode, sel, out_ready,
        input  in_ready, out_data, out_valid, out_ch, err
    );
    modport slave (
        input  in_data, in_valid, mode, sel, out_ready,
        output in_ready, out_data, out_valid, out_ch, err
    );
endinterface

// File: rtl/mux_arb_n.sv
// mux_arb_n: N-channel registered mux/arbiter, explicit select or round-robin.
// Define MUX_SEL_CHECK_EN to build the sticky out-of-range select flag on err.
module mux_arb_n #(
    parameter int WIDTH = 4,
    parameter int NCH   = 3,
    parameter int SELW  = 2
) (
    input logic      clk,
    input logic      rst_n,
    mux_arb_n_if.slave bus
);
    typedef enum logic {EMPTY, FULL} state_t;
    state_t state, state_nxt;
    logic [SELW-1:0] ptr, gidx, c, ch_q;
    logic [NCH-1:0] grant;
    logic [WIDTH-1:0] data_q;
    logic load_en, any;
    always_comb begin
        grant = '0;
        gidx = bus.sel;
        c = '0;
        if (!bus.mode) begin
            if (int'(bus.sel) < NCH && bus.in_valid[bus.sel]) grant[bus.sel] = 1'b1;
        end else begin
            // scan from the far end so the nearest channel after ptr wins
            for (int k = NCH; k >= 1; k--) begin
                c = SELW'((int'(ptr) + k) % NCH);
                if (bus.in_valid[c]) begin
                    grant = '0;
                    grant[c] = 1'b1;
                    gidx = c;
                end
            end
        end
    end
    assign any = |grant;
    assign load_en = state == EMPTY || bus.out_ready;
    assign bus.in_ready = rst_n ? grant & {NCH{load_en}} : '0;
    assign bus.out_valid = state == FULL;
    assign bus.out_data = data_q;
    assign bus.out_ch = ch_q;
    always_comb begin
        state_nxt = state;
        if (load_en) state_nxt = any ? FULL : EMPTY;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= EMPTY;
            data_q <= '0;
            ch_q <= '0;
            ptr <= SELW'(NCH - 1);
        end else begin
            state <= state_nxt;
            if (load_en && any) begin
                data_q <= bus.in_data[gidx*WIDTH +: WIDTH];
                ch_q <= gidx;
                ptr <= gidx;
            end
        end
    end
`ifdef MUX_SEL_CHECK_EN
    logic err_q;
    always_ff @(posedge clk) begin
        if (!rst_n) err_q <= 1'b0;
        else if (!bus.mode && int'(bus.sel) >= NCH) err_q <= 1'b1;
    end
    assign bus.err = err_q;
`else
    assign bus.err = 1'b0;
`endif
endmodule

// File: tb/tb_mux_arb_n.sv
// tb_mux_arb_n: scoreboard bench for mux_arb_n; expected beats are queued at grant time
// and compared when the consumer pops them.
module tb_mux_arb_n;
    localparam int WIDTH = 4, NCH = 3, SELW = 2;
    logic clk = 1'b0, rst_n = 1'b0;
    int n_chk = 0, n_fail = 0;
    logic [SELW+WIDTH-1:0] sb[$];
    logic m_valid = 1'b0, m_err = 1'b0;
    int m_ptr = NCH - 1, g;
    logic m_load;
    mux_arb_n_if #(.WIDTH(WIDTH), .NCH(NCH), .SELW(SELW)) bus ();
    mux_arb_n #(.WIDTH(WIDTH), .NCH(NCH), .SELW(SELW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask
    task automatic step();
        logic [NCH-1:0] exp_ready;
        @(negedge clk);
        g = -1;
        exp_ready = '0;
        m_load = !m_valid || bus.out_ready;
        if (!bus.mode) begin
            if (int'(bus.sel) < NCH && bus.in_valid[bus.sel]) g = int'(bus.sel);
        end else begin
            for (int k = 1; k <= NCH; k++)
                if (g < 0 && bus.in_valid[(m_ptr + k) % NCH]) g = (m_ptr + k) % NCH;
        end
        if (rst_n && m_load && g >= 0) exp_ready[g] = 1'b1;
        check("in_ready", 32'(bus.in_ready), 32'(exp_ready));
        check("out_valid", 32'(bus.out_valid), 32'(m_valid));
        check("err", 32'(bus.err), 32'(m_err));
        if (rst_n && m_valid && bus.out_ready) begin
            if (sb.size() == 0) check("sb_underflow", 32'(1), 32'(0));
            else check("out_beat", 32'({bus.out_ch, bus.out_data}), 32'(sb.pop_front()));
        end
        if (rst_n && m_load && g >= 0) sb.push_back({SELW'(g), bus.in_data[g*WIDTH +: WIDTH]});
        @(posedge clk);
        if (!rst_n) begin
            m_valid = 1'b0;
            m_ptr = NCH - 1;
            m_err = 1'b0;
            sb.delete();
        end else begin
`ifdef MUX_SEL_CHECK_EN
            if (!bus.mode && int'(bus.sel) >= NCH) m_err = 1'b1;
`endif
            if (m_load) begin
                m_valid = g >= 0;
                if (g >= 0) m_ptr = g;
            end
        end
        #1;
    endtask
    initial begin
        bus.in_data = {4'h3, 4'h2, 4'h1};
        bus.in_valid = 3'b111;
        bus.mode = 1'b0;
        bus.sel = 2'd0;
        bus.out_ready = 1'b1;
        rst_n = 1'b0;
        repeat (2) begin
            step();
            check("rst_data", 32'(bus.out_data), 32'(0));
            check("rst_ch", 32'(bus.out_ch), 32'(0));
        end
        rst_n = 1'b1;
        bus.mode = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            check("rr_ch", 32'(bus.out_ch), 32'(i % NCH));
            check("rr_data", 32'(bus.out_data), 32'(i % NCH + 1));
        end
        bus.mode = 1'b0;
        bus.sel = 2'd1;
        bus.in_data = {4'h3, 4'hA, 4'h1};
        step();
        check("sel1_data", 32'(bus.out_data), 32'hA);
        check("sel1_ch", 32'(bus.out_ch), 32'(1));
        bus.sel = 2'd2;
        bus.in_data = {4'h5, 4'hA, 4'h7};
        step();
        check("bp_load", 32'(bus.out_data), 32'h5);
        bus.out_ready = 1'b0;
        bus.sel = 2'd0;
        bus.in_valid = 3'b001;
        repeat (3) begin
            step();
            check("bp_hold", 32'(bus.out_data), 32'h5);
        end
        bus.out_ready = 1'b1;
        step();
        check("bp_release", 32'(bus.out_data), 32'h7);
        bus.sel = 2'd3;
        bus.in_valid = 3'b111;
        step();
        check("sel3_valid", 32'(bus.out_valid), 32'(0));
        step();
        bus.sel = 2'd1;
        step();
        bus.out_ready = 1'b0;
        step();
        rst_n = 1'b0;
        step();
        check("mid_rst_valid", 32'(bus.out_valid), 32'(0));
        rst_n = 1'b1;
        bus.mode = 1'b1;
        bus.out_ready = 1'b1;
        step();
        check("post_rst_ch", 32'(bus.out_ch), 32'(0));
        for (int i = 0; i < 60; i++) begin
            bus.mode = 1'($urandom_range(0, 1));
            bus.sel = SELW'($urandom_range(0, 3));
            bus.in_valid = NCH'($urandom);
            bus.in_data = (NCH*WIDTH)'($urandom);
            bus.out_ready = 1'($urandom_range(0, 3) != 0);
            step();
        end
        bus.in_valid = '0;
        bus.out_ready = 1'b1;
        repeat (3) step();
        check("sb_drained", 32'(sb.size()), 32'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
